// File: rtl/btn_scan_arbiter.sv
// Button debouncer with shared tick prescaler, per-button pending slots, round-robin
// arbitration and an event FIFO. Define BTN_SCAN_TIMESTAMP_EN to add o_evt_ts.
module btn_scan_arbiter #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 1024,
  parameter int STABLE_TICKS = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int IDW         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_state,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic [IDW-1:0]   o_evt_id,
  output logic             o_evt_up,
  output logic             o_overflow,
  input  logic             i_clr_ovf
`ifdef BTN_SCAN_TIMESTAMP_EN
  ,
  output logic [15:0]      o_evt_ts
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N_BTN-1:0]               sync1_q, sync1_d;
  logic [N_BTN-1:0]               sync2_q, sync2_d;
  logic [PW-1:0]                  presc_q, presc_d;
  logic                           tick;
  logic [N_BTN-1:0][CW-1:0]       cnt_q, cnt_d;
  logic [N_BTN-1:0]               state_q, state_d;
  logic [N_BTN-1:0]               raise;
  logic [N_BTN-1:0]               accept;
  logic [N_BTN-1:0]               pend_q, pend_d;
  logic [N_BTN-1:0]               dir_q, dir_d;
  logic [IDW-1:0]                 rr_q, rr_d;
  logic [IDW-1:0]                 gnt_idx;
  logic                           gnt_found;
  logic                           grant;
  logic                           pop;
  logic                           full;
  logic                           ovf_set;
  logic                           ovf_q, ovf_d;
  logic [FIFO_DEPTH-1:0][IDW:0]   mem_q, mem_d;
  logic [AW-1:0]                  wr_q, wr_d;
  logic [AW-1:0]                  rd_q, rd_d;
  logic [AW:0]                    fcnt_q, fcnt_d;

  // Synchroniser and shared sample-tick prescaler
  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Per-button stability counters: a new level needs STABLE_TICKS mismatching ticks in a row
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    raise   = '0;
    if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
          state_d[i] = ~state_q[i];
          cnt_d[i]   = '0;
          raise[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin search over pending slots starting at rr_q
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_v;
    idx       = 0;
    idx_v     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      idx_v = IDW'(idx);
      if (!gnt_found && pend_q[idx_v]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_v;
      end
    end
  end

  assign full        = (fcnt_q == (AW + 1)'(FIFO_DEPTH));
  assign o_evt_valid = (fcnt_q != '0);
  assign pop         = o_evt_valid & i_evt_ready;
  assign grant       = gnt_found & (~full | pop);

  // Pending slots: a slot freed by this cycle's grant may take a new event without loss
  always_comb begin
    pend_d  = pend_q;
    dir_d   = dir_q;
    accept  = '0;
    ovf_set = 1'b0;
    rr_d    = rr_q;
    if (grant) begin
      pend_d[gnt_idx] = 1'b0;
      rr_d = (gnt_idx == IDW'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (raise[i]) begin
        if (pend_q[i] && !(grant && (gnt_idx == IDW'(i)))) begin
          ovf_set = 1'b1;
        end else begin
          accept[i] = 1'b1;
          pend_d[i] = 1'b1;
          dir_d[i]  = state_d[i];
        end
      end
    end
    ovf_d = ovf_set | (ovf_q & ~i_clr_ovf);
  end

  // Event FIFO
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    if (grant) begin
      mem_d[wr_q] = {gnt_idx, dir_q[gnt_idx]};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (grant && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (pop && !grant) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      state_q <= '0;
      pend_q  <= '0;
      dir_q   <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_state    = state_q;
  assign o_overflow = ovf_q;
  assign o_evt_id   = mem_q[rd_q][IDW:1];
  assign o_evt_up   = mem_q[rd_q][0];

`ifdef BTN_SCAN_TIMESTAMP_EN
  logic [15:0]                  ts_q, ts_d;
  logic [N_BTN-1:0][15:0]       pts_q, pts_d;
  logic [FIFO_DEPTH-1:0][15:0]  tsm_q, tsm_d;

  // Timestamp travels with the event: stamped on raise, carried through slot and FIFO
  always_comb begin
    ts_d  = tick ? ts_q + 16'd1 : ts_q;
    pts_d = pts_q;
    tsm_d = tsm_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (accept[i]) pts_d[i] = ts_q;
    end
    if (grant) tsm_d[wr_q] = pts_q[gnt_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q  <= '0;
      pts_q <= '0;
      tsm_q <= '0;
    end else begin
      ts_q  <= ts_d;
      pts_q <= pts_d;
      tsm_q <= tsm_d;
    end
  end

  assign o_evt_ts = tsm_q[rd_q];
`endif

endmodule

// File: tb/tb_btn_scan_arbiter.sv
// Directed bench for btn_scan_arbiter with TICK_DIV=4, STABLE_TICKS=3, N_BTN=4, FIFO_DEPTH=4.
module tb_btn_scan_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] o_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_up;
  logic       ovf;
  logic       clr_ovf;
`ifdef BTN_SCAN_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  btn_scan_arbiter #(
    .N_BTN(4),
    .TICK_DIV(4),
    .STABLE_TICKS(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_btn(btn),
    .o_state(o_state),
    .o_evt_valid(evt_valid),
    .i_evt_ready(evt_ready),
    .o_evt_id(evt_id),
    .o_evt_up(evt_up),
    .o_overflow(ovf),
    .i_clr_ovf(clr_ovf)
`ifdef BTN_SCAN_TIMESTAMP_EN
    ,
    .o_evt_ts(evt_ts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [1:0] id, input logic up);
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_id"}, 32'(evt_id), 32'(id));
    check({tag, "_up"}, 32'(evt_up), 32'(up));
  endtask

  task automatic wait_state(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 60 && o_state !== exp; i++) step(1);
    check({tag, "_state"}, 32'(o_state), 32'(exp));
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    btn       = 4'b0001;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    step(3);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // Single press: ticks at edges 4,8,12 -> o_state at 12, valid at 13
    rst_n = 1'b1;
    step(11);
    check("sp_early_state", 32'(o_state), 32'd0);
    step(1);
    check("sp_state", 32'(o_state), 32'h1);
    check("sp_valid_lat", 32'(evt_valid), 32'd0);
    step(1);
    check_head("sp_head", 2'd0, 1'b1);
    pop_one();
    check("sp_pop", 32'(evt_valid), 32'd0);

    // Bounce: btn1 alternates every tick, never 3 mismatching ticks in a row
    step(2);
    for (int k = 0; k < 8; k++) begin
      btn[1] = ~btn[1];
      step(4);
    end
    check("bnc_state", 32'(o_state), 32'h1);
    check("bnc_valid", 32'(evt_valid), 32'd0);
    check("bnc_ovf", 32'(ovf), 32'd0);

    // Round-robin: press btn1 to move rr_ptr to 2, then 1,2,3 on the same tick
    btn[1] = 1'b1;
    wait_state("rr_pre", 4'b0011);
    step(1);
    check_head("rr_pre", 2'd1, 1'b1);
    pop_one();
    btn = 4'b1101;
    wait_state("rr", 4'b1101);
    step(4);
    check_head("rr0", 2'd2, 1'b1);
    evt_ready = 1'b1;
    step(1);
    check_head("rr1", 2'd3, 1'b1);
    step(1);
    check_head("rr2", 2'd1, 1'b0);
    step(1);
    check("rr_empty", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Backpressure: four edges fill the FIFO, two more wait in pending slots
    btn[0] = 1'b0; wait_state("bp1", 4'b1100);
    btn[1] = 1'b1; wait_state("bp2", 4'b1110);
    btn[2] = 1'b0; wait_state("bp3", 4'b1010);
    btn[3] = 1'b0; wait_state("bp4", 4'b0010);
    btn[0] = 1'b1; wait_state("bp5", 4'b0011);
    btn[1] = 1'b0; wait_state("bp6", 4'b0001);
    step(2);
    check_head("bp_hold", 2'd0, 1'b0);
    check("bp_ovf0", 32'(ovf), 32'd0);
    begin
      logic [1:0] exp_id [6];
      logic       exp_up [6];
      exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      exp_up = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      evt_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
        check_head($sformatf("bp_evt%0d", k), exp_id[k], exp_up[k]);
        step(1);
      end
      evt_ready = 1'b0;
    end
    check("bp_empty", 32'(evt_valid), 32'd0);
    check("bp_ovf", 32'(ovf), 32'd0);

    // Overflow: FIFO full, btn0 press pends, its release is dropped
    btn[0] = 1'b0; wait_state("of1", 4'b0000);
    btn[1] = 1'b1; wait_state("of2", 4'b0010);
    btn[2] = 1'b1; wait_state("of3", 4'b0110);
    btn[3] = 1'b1; wait_state("of4", 4'b1110);
    btn[0] = 1'b1; wait_state("of5", 4'b1111);
    check("of_ovf_before", 32'(ovf), 32'd0);
    btn[0] = 1'b0; wait_state("of6", 4'b1110);
    check("of_ovf_set", 32'(ovf), 32'd1);
    step(4);
    check_head("of_hold", 2'd0, 1'b0);
    begin
      logic [1:0] exp_id [5];
      logic       exp_up [5];
      exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_up = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      evt_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
        check_head($sformatf("of_evt%0d", k), exp_id[k], exp_up[k]);
        step(1);
      end
    end
    step(8);
    evt_ready = 1'b0;
    check("of_empty", 32'(evt_valid), 32'd0);
    check("of_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("of_clr", 32'(ovf), 32'd0);

    // Reset mid-operation with three events queued
    btn[1] = 1'b0; wait_state("mr1", 4'b1100);
    btn[1] = 1'b1; wait_state("mr2", 4'b1110);
    btn[0] = 1'b1; wait_state("mr3", 4'b1111);
    step(2);
    check_head("mr_queued", 2'd1, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mr_valid_async", 32'(evt_valid), 32'd0);
    check("mr_state_async", 32'(o_state), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(11);
    check("mr_early_state", 32'(o_state), 32'd0);
    step(1);
    check("mr_state", 32'(o_state), 32'hF);
    check("mr_valid_lat", 32'(evt_valid), 32'd0);
    step(1);
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_head($sformatf("mr_evt%0d", k), 2'(k), 1'b1);
      step(1);
    end
    evt_ready = 1'b0;
    check("mr_empty", 32'(evt_valid), 32'd0);
    check("mr_ovf", 32'(ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
